// File: rtl/frame_pkg.sv
// Shared definitions for the packet synchroniser and the downstream frame checker.
package frame_pkg;

    // Default packet framing constants.
    localparam int          DEF_HDR_W   = 16;
    localparam logic [15:0] DEF_HEADER  = 16'hF628;
    localparam int          DEF_PKT_LEN = 27;

    // Alignment search states of packet_sync.
    typedef enum logic [1:0] {
        SYNC_HUNT   = 2'd0,
        SYNC_VERIFY = 2'd1,
        SYNC_LOCKED = 2'd2
    } sync_state_t;

    // Frame checker walk: one state per word of a 27-word packet.
    typedef enum logic [4:0] {
        IDLE, FRAME1, FRAME2, FRAME3, FRAME4, FRAME5, FRAME6, FRAME7, FRAME8,
        FRAME9, FRAME10, FRAME11, FRAME12, FRAME13, FRAME14, FRAME15, FRAME16,
        FRAME17, FRAME18, FRAME19, FRAME20, FRAME21, FRAME22, FRAME23, FRAME24,
        FRAME25, FRAME_TAIL
    } frame_state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value; cleared only by reset.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk_390p625M,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Count enabled events, holding once the maximum is reached.
    always_ff @(posedge clk_390p625M or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/packet_sync.sv
// Packet header search, alignment confirmation and flywheel lock for the
// frame checker. Outputs are registered and aligned with data_out.
//
// state       | meaning
// ------------+----------------------------------------------------------
// SYNC_HUNT   | examine every word for the header pattern
// SYNC_VERIFY | header seen; confirm headers at the expected slot spacing
// SYNC_LOCKED | aligned; emit start pulses, tolerate isolated misses
module packet_sync
    import frame_pkg::*;
#(
    parameter int                HDR_W      = DEF_HDR_W,
    parameter logic [HDR_W-1:0]  HEADER     = DEF_HEADER,
    parameter int                PKT_LEN    = DEF_PKT_LEN,
    parameter int                LOCK_CNT   = 3,
    parameter int                UNLOCK_CNT = 4
) (
    input  logic        clk_390p625M,
    input  logic        rst_n,
    input  logic [61:0] unscrambled_data,
    output logic [61:0] data_out,
    output logic        data_packet_start,
    output logic        sync_locked,
    output logic        lock_lost,
    output logic [15:0] hdr_miss_cnt
);

    localparam int POS_W  = $clog2(PKT_LEN);
    localparam int GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int MISS_W = $clog2(UNLOCK_CNT + 1);

    sync_state_t       state, state_nxt;
    logic [POS_W-1:0]  pos, pos_nxt, pos_adv;
    logic [GOOD_W-1:0] good_cnt, good_nxt, good_inc;
    logic [MISS_W-1:0] miss_cnt, miss_nxt, miss_inc;
    logic              hdr_match, slot, lock_done, miss_limit;
    logic              start_nxt, lost_nxt, miss_evt;

    assign hdr_match  = (unscrambled_data[HDR_W-1:0] == HEADER);
    assign slot       = (pos == '0);
    assign pos_adv    = (pos == POS_W'(PKT_LEN - 1)) ? '0 : pos + 1'b1;
    assign good_inc   = good_cnt + 1'b1;
    assign miss_inc   = miss_cnt + 1'b1;
    assign lock_done  = (good_inc == GOOD_W'(LOCK_CNT));
    assign miss_limit = (miss_inc == MISS_W'(UNLOCK_CNT));

    // State and alignment counters.
    always_ff @(posedge clk_390p625M or negedge rst_n) begin
        if (!rst_n) begin
            state    <= SYNC_HUNT;
            pos      <= '0;
            good_cnt <= '0;
            miss_cnt <= '0;
        end else begin
            state    <= state_nxt;
            pos      <= pos_nxt;
            good_cnt <= good_nxt;
            miss_cnt <= miss_nxt;
        end
    end

    // Next state; the slot position restarts so the word after a header is pos 1.
    always_comb begin
        state_nxt = state;
        pos_nxt   = pos_adv;
        good_nxt  = good_cnt;
        miss_nxt  = miss_cnt;
        case (state)
            SYNC_HUNT: begin
                pos_nxt  = '0;
                good_nxt = '0;
                miss_nxt = '0;
                if (hdr_match) begin
                    state_nxt = SYNC_VERIFY;
                    good_nxt  = GOOD_W'(1);
                    pos_nxt   = POS_W'(1);
                end
            end
            SYNC_VERIFY: begin
                if (slot) begin
                    if (hdr_match) begin
                        good_nxt = good_inc;
                        if (lock_done) begin
                            state_nxt = SYNC_LOCKED;
                            miss_nxt  = '0;
                        end
                    end else begin
                        state_nxt = SYNC_HUNT;
                        pos_nxt   = '0;
                        good_nxt  = '0;
                    end
                end
            end
            SYNC_LOCKED: begin
                if (slot) begin
                    if (hdr_match) begin
                        miss_nxt = '0;
                    end else if (miss_limit) begin
                        state_nxt = SYNC_HUNT;
                        pos_nxt   = '0;
                        good_nxt  = '0;
                        miss_nxt  = '0;
                    end else begin
                        miss_nxt = miss_inc;
                    end
                end
            end
            default: begin
                state_nxt = SYNC_HUNT;
                pos_nxt   = '0;
                good_nxt  = '0;
                miss_nxt  = '0;
            end
        endcase
    end

    // Pulse decisions for the current word; start pulses only ever come from LOCKED slots
    // (including the header that completes the lock).
    always_comb begin
        start_nxt = 1'b0;
        lost_nxt  = 1'b0;
        miss_evt  = 1'b0;
        case (state)
            SYNC_VERIFY: start_nxt = slot && hdr_match && lock_done;
            SYNC_LOCKED: begin
                if (slot) begin
                    if (hdr_match) begin
                        start_nxt = 1'b1;
                    end else begin
                        miss_evt = 1'b1;
                        if (miss_limit) begin
                            lost_nxt = 1'b1;
                        end else begin
                            start_nxt = 1'b1;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    // Register outputs so flags line up with the delayed data word.
    always_ff @(posedge clk_390p625M or negedge rst_n) begin
        if (!rst_n) begin
            data_out          <= '0;
            data_packet_start <= 1'b0;
            lock_lost         <= 1'b0;
            sync_locked       <= 1'b0;
        end else begin
            data_out          <= unscrambled_data;
            data_packet_start <= start_nxt;
            lock_lost         <= lost_nxt;
            sync_locked       <= (state_nxt == SYNC_LOCKED);
        end
    end

    sat_counter #(
        .WIDTH(16)
    ) u_miss_cnt (
        .clk_390p625M(clk_390p625M),
        .rst_n       (rst_n),
        .inc         (miss_evt),
        .count       (hdr_miss_cnt)
    );

endmodule

// File: tb/tb_packet_sync.sv
// Self-checking bench for packet_sync with a slot-schedule reference model.
module tb_packet_sync;

    localparam int          PL  = 27;
    localparam logic [15:0] HDR = 16'hF628;

    logic        clk_390p625M = 1'b0;
    logic        rst_n;
    logic [61:0] unscrambled_data;
    logic [61:0] data_out;
    logic        data_packet_start;
    logic        sync_locked;
    logic        lock_lost;
    logic [15:0] hdr_miss_cnt;

    logic        sc_rst_n;
    logic        sc_inc;
    logic [2:0]  sc_count;

    int errors = 0;
    int checks = 0;

    // Reference model: absolute cycle numbers and the cycle of the next expected header.
    int m_n, m_next, m_conf, m_miss, m_total;
    bit m_hunting, m_locked;
    logic [61:0] e_data;
    logic        e_start, e_lost, e_locked;
    logic [15:0] e_cnt;
    logic [80:0] obs, expv;

    packet_sync dut (
        .clk_390p625M     (clk_390p625M),
        .rst_n            (rst_n),
        .unscrambled_data (unscrambled_data),
        .data_out         (data_out),
        .data_packet_start(data_packet_start),
        .sync_locked      (sync_locked),
        .lock_lost        (lock_lost),
        .hdr_miss_cnt     (hdr_miss_cnt)
    );

    sat_counter #(.WIDTH(3)) u_sc (
        .clk_390p625M(clk_390p625M),
        .rst_n       (sc_rst_n),
        .inc         (sc_inc),
        .count       (sc_count)
    );

    always #2 clk_390p625M = ~clk_390p625M;

    function automatic logic [61:0] payload();
        logic [63:0] r;
        logic [61:0] w;
        r = {$urandom(), $urandom()};
        w = r[61:0];
        if (w[15:0] == HDR) w[0] = ~w[0];
        return w;
    endfunction

    function automatic logic [61:0] hdr_word();
        logic [61:0] w;
        w = payload();
        w[15:0] = HDR;
        return w;
    endfunction

    task automatic model_reset();
        m_n = 0; m_next = 0; m_conf = 0; m_miss = 0; m_total = 0;
        m_hunting = 1'b1; m_locked = 1'b0;
        e_data = '0; e_start = 1'b0; e_lost = 1'b0; e_locked = 1'b0; e_cnt = '0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        unscrambled_data = '0;
        repeat (3) @(posedge clk_390p625M);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    // Drive one word, advance the model by one cycle and capture DUT outputs.
    task automatic drive_word(input logic [61:0] w);
        bit match;
        unscrambled_data = w;
        @(posedge clk_390p625M);
        #1;
        m_n++;
        match = (w[15:0] == HDR);
        e_data = w; e_start = 1'b0; e_lost = 1'b0;
        if (m_hunting) begin
            if (match) begin
                m_hunting = 1'b0; m_conf = 1; m_next = m_n + PL;
            end
        end else if (m_n == m_next) begin
            m_next = m_n + PL;
            if (!m_locked) begin
                if (match) begin
                    m_conf++;
                    if (m_conf == 3) begin m_locked = 1'b1; m_miss = 0; e_start = 1'b1; end
                end else begin
                    m_hunting = 1'b1; m_conf = 0;
                end
            end else if (match) begin
                m_miss = 0; e_start = 1'b1;
            end else begin
                m_miss++;
                if (m_total < 65535) m_total++;
                if (m_miss < 4) e_start = 1'b1;
                else begin
                    m_locked = 1'b0; m_hunting = 1'b1; m_miss = 0; m_conf = 0; e_lost = 1'b1;
                end
            end
        end
        e_locked = m_locked;
        e_cnt = 16'(m_total);
        obs  = {data_out, data_packet_start, lock_lost, sync_locked, hdr_miss_cnt};
        expv = {e_data, e_start, e_lost, e_locked, e_cnt};
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sc_rst_n = 1'b0; sc_inc = 1'b0; unscrambled_data = '1;
        repeat (2) @(posedge clk_390p625M);
        #1;
        obs = {data_out, data_packet_start, lock_lost, sync_locked, hdr_miss_cnt};
        if (obs !== 81'd0) begin
            errors++; $display("FAIL reset_outputs got=%h exp=0", obs);
        end
        checks++;
        if (sc_count !== 3'd0) begin
            errors++; $display("FAIL reset_sat got=%0d exp=0", sc_count);
        end
        checks++;
        sc_rst_n = 1'b1;
        apply_reset();
    endtask

    task automatic test_clean_lock();
        int pulses = 0, stray = 0, first = 0, k = 0;
        apply_reset();
        for (int p = 0; p < 6; p++) begin
            for (int i = 0; i < PL; i++) begin
                drive_word(i == 0 ? hdr_word() : payload());
                k++;
                if (obs !== expv) begin
                    errors++; $display("FAIL clean_lock p=%0d i=%0d got=%h exp=%h", p, i, obs, expv);
                end
                checks++;
                if (data_packet_start) begin
                    if (i == 0) pulses++; else stray++;
                    if (first == 0) first = k;
                end
            end
        end
        if (pulses !== 4 || stray !== 0) begin
            errors++; $display("FAIL clean_lock_pulses got=%0d/%0d exp=4/0", pulses, stray);
        end
        checks++;
        if (first !== 55) begin
            errors++; $display("FAIL clean_lock_first got=%0d exp=55", first);
        end
        checks++;
        if (sync_locked !== 1'b1) begin
            errors++; $display("FAIL clean_lock_locked got=%b exp=1", sync_locked);
        end
        checks++;
    endtask

    task automatic test_false_header();
        int pulses = 0;
        apply_reset();
        for (int i = 0; i < 51; i++) begin
            drive_word(i == 10 ? hdr_word() : payload());
            if (obs !== expv) begin
                errors++; $display("FAIL false_hdr i=%0d got=%h exp=%h", i, obs, expv);
            end
            checks++;
            if (data_packet_start) pulses++;
        end
        if (pulses !== 0 || sync_locked !== 1'b0) begin
            errors++; $display("FAIL false_hdr_nolock got=%0d/%b exp=0/0", pulses, sync_locked);
        end
        checks++;
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < PL; i++) begin
                drive_word(i == 0 ? hdr_word() : payload());
                if (obs !== expv) begin
                    errors++; $display("FAIL false_hdr_train p=%0d i=%0d got=%h exp=%h", p, i, obs, expv);
                end
                checks++;
                if (data_packet_start) pulses++;
            end
        end
        if (pulses !== 2 || sync_locked !== 1'b1) begin
            errors++; $display("FAIL false_hdr_relock got=%0d/%b exp=2/1", pulses, sync_locked);
        end
        checks++;
    endtask

    task automatic test_flywheel();
        int pulses = 0, stray = 0;
        for (int p = 0; p < 5; p++) begin
            for (int i = 0; i < PL; i++) begin
                drive_word((i == 0 && p >= 3) ? hdr_word() : payload());
                if (obs !== expv) begin
                    errors++; $display("FAIL flywheel p=%0d i=%0d got=%h exp=%h", p, i, obs, expv);
                end
                checks++;
                if (data_packet_start) begin
                    if (i == 0) pulses++; else stray++;
                end
                if (p == 2 && i == 0) begin
                    if (hdr_miss_cnt !== 16'd3 || sync_locked !== 1'b1) begin
                        errors++; $display("FAIL flywheel_cnt got=%0d/%b exp=3/1", hdr_miss_cnt, sync_locked);
                    end
                    checks++;
                end
            end
        end
        if (pulses !== 5 || stray !== 0) begin
            errors++; $display("FAIL flywheel_pulses got=%0d/%0d exp=5/0", pulses, stray);
        end
        checks++;
    endtask

    task automatic test_loss_of_lock();
        int pulses = 0, lost = 0;
        for (int p = 0; p < 5; p++) begin
            for (int i = 0; i < PL; i++) begin
                drive_word(payload());
                if (obs !== expv) begin
                    errors++; $display("FAIL loss p=%0d i=%0d got=%h exp=%h", p, i, obs, expv);
                end
                checks++;
                if (data_packet_start) pulses++;
                if (lock_lost) lost++;
                if (p == 3 && i == 0) begin
                    if (lock_lost !== 1'b1 || data_packet_start !== 1'b0 || sync_locked !== 1'b0) begin
                        errors++; $display("FAIL loss_slot4 got=%b%b%b exp=100", lock_lost, data_packet_start, sync_locked);
                    end
                    checks++;
                end
            end
        end
        if (pulses !== 3 || lost !== 1) begin
            errors++; $display("FAIL loss_counts got=%0d/%0d exp=3/1", pulses, lost);
        end
        checks++;
        if (hdr_miss_cnt !== 16'd7) begin
            errors++; $display("FAIL loss_miss_cnt got=%0d exp=7", hdr_miss_cnt);
        end
        checks++;
    endtask

    task automatic test_saturation();
        int exp_sc = 0;
        sc_rst_n = 1'b0; sc_inc = 1'b0;
        @(posedge clk_390p625M);
        #1;
        sc_rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            sc_inc = (k != 3 && k != 11);
            @(posedge clk_390p625M);
            #1;
            if (sc_inc && exp_sc < 7) exp_sc++;
            if (sc_count !== 3'(exp_sc)) begin
                errors++; $display("FAIL saturation k=%0d got=%0d exp=%0d", k, sc_count, exp_sc);
            end
            checks++;
        end
        sc_inc = 1'b0;
    endtask

    task automatic test_reset_mid_packet();
        int pulses = 0, first = 0, k = 0;
        apply_reset();
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < PL; i++) begin
                if (p == 3 && i == 13) break;
                drive_word(i == 0 ? hdr_word() : payload());
                if (obs !== expv) begin
                    errors++; $display("FAIL midrst_pre p=%0d i=%0d got=%h exp=%h", p, i, obs, expv);
                end
                checks++;
            end
        end
        rst_n = 1'b0;
        #1;
        obs = {data_out, data_packet_start, lock_lost, sync_locked, hdr_miss_cnt};
        if (obs !== 81'd0) begin
            errors++; $display("FAIL midrst_outputs got=%h exp=0", obs);
        end
        checks++;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            drive_word(payload());
            if (obs !== expv) begin
                errors++; $display("FAIL midrst_idle i=%0d got=%h exp=%h", i, obs, expv);
            end
            checks++;
        end
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < PL; i++) begin
                drive_word(i == 0 ? hdr_word() : payload());
                k++;
                if (obs !== expv) begin
                    errors++; $display("FAIL midrst_relock p=%0d i=%0d got=%h exp=%h", p, i, obs, expv);
                end
                checks++;
                if (data_packet_start) begin
                    pulses++;
                    if (first == 0) first = k;
                end
            end
        end
        if (first !== 55 || pulses !== 1) begin
            errors++; $display("FAIL midrst_first got=%0d/%0d exp=55/1", first, pulses);
        end
        checks++;
    endtask

    initial begin
        test_reset();
        test_clean_lock();
        test_false_header();
        test_flywheel();
        test_loss_of_lock();
        test_saturation();
        test_reset_mid_packet();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/packet_sync.md
# packet_sync

- Upstream stage of the frame checker.
- Searches the unscrambled 62-bit word stream for the packet header and confirms packet alignment over several consecutive packets.
- Once locked, drives a one-cycle `data_packet_start` pulse aligned with a one-cycle-delayed copy of the data, so the frame checker's IDLE→FRAME1…FRAME25→FRAME_TAIL walk lands on real packet boundaries.
- A flywheel tolerates isolated header misses before dropping lock.

## Interface

Parameters:
- `HDR_W`, 16: header field width, compared against `data[HDR_W-1:0]`.
- `HEADER`, 16'hF628: header pattern.
- `PKT_LEN`, 27: words per packet (header + 25 payload + tail).
- `LOCK_CNT`, 3: consecutive correctly spaced headers required to lock.
- `UNLOCK_CNT`, 4: consecutive missed headers that drop lock.

Ports:
- `clk_390p625M`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `unscrambled_data`  in  62  descrambler output, one word per cycle, always valid.
- `data_out`  out  62  `unscrambled_data` delayed one cycle; feeds the frame checker.
- `data_packet_start`  out  1  one-cycle pulse, coincident with the header word on `data_out`.
- `sync_locked`  out  1  high in LOCKED.
- `lock_lost`  out  1  one-cycle pulse on LOCKED→HUNT.
- `hdr_miss_cnt`  out  16  saturating count of missed expected headers while locked.

## Operation

Definitions:
- A word matches when `unscrambled_data[HDR_W-1:0] == HEADER`.
- `pos` is a 0..PKT_LEN-1 counter that wraps. `pos==0` is the expected-header slot.
- `good_cnt` counts confirmed headers. `miss_cnt` counts consecutive misses.

State machine (`sync_state_t`):
- **HUNT**:
  - Match → VERIFY, `good_cnt`=1, `pos` restarts so the next word is pos 1.
  - No match → stay.
  - `pos`, `miss_cnt` are held at 0.
- **VERIFY**:
  - `pos` advances each cycle. Words at pos≠0 are ignored.
  - At pos 0, match → `good_cnt`+1. If `good_cnt` reaches LOCK_CNT → LOCKED, and this header produces `data_packet_start`.
  - At pos 0, mismatch → HUNT. The mismatching word is not re-examined as a header.
- **LOCKED**:
  - At pos 0, match → start pulse, `miss_cnt`=0.
  - At pos 0, mismatch → `miss_cnt`+1 and `hdr_miss_cnt`+1 (saturating at 16'hFFFF).
    - If `miss_cnt` < UNLOCK_CNT: the start pulse is still issued (flywheel).
    - If `miss_cnt` reaches UNLOCK_CNT: no start pulse, → HUNT, `lock_lost` pulse.
  - Matches at pos≠0 are ignored.
- `data_packet_start` is only ever produced in LOCKED (including the lock-completing header). Pulses are therefore exactly PKT_LEN cycles apart, which matches the frame checker's 27-cycle IDLE→…→FRAME_TAIL→IDLE cycle.
- `hdr_miss_cnt` is cleared only by reset. It does not change in HUNT or VERIFY.
- Undefined state encodings → HUNT.

## Timing

- All outputs are registered. Latency is 1 cycle: a word at the input in cycle t appears on `data_out` at t+1.
- `data_packet_start`, `lock_lost`, `sync_locked`, and `hdr_miss_cnt` updates for the word at cycle t appear at t+1, aligned with that word on `data_out`.
- The tail word appears on `data_out` PKT_LEN-1 = 26 cycles after the start pulse.
- Reset values: `data_out`=0, `data_packet_start`=0, `sync_locked`=0, `lock_lost`=0, `hdr_miss_cnt`=0. Internal state: HUNT, `pos`=0, `good_cnt`=0, `miss_cnt`=0.
- Reset mid-packet aborts immediately with no pulse. On release, the block re-hunts from the first word.
- Minimum time to first start pulse: (LOCK_CNT-1)·PKT_LEN+1 cycles after the first header enters. Default: 55 cycles.
- `sync_locked` rises with the lock-completing start pulse and falls with `lock_lost`.

## Structure

- Shared package `frame_pkg` holds:
  - `sync_state_t`
  - `PKT_LEN`, `HEADER`, `HDR_W` default constants
  - the frame checker's `frame_state_t`, moved here so both blocks share one definition.
- One sub-module: `sat_counter` (parameterised width, increment enable, synchronous hold at max) for `hdr_miss_cnt`.
- FSM, `pos`, `good_cnt`, and `miss_cnt` stay in `packet_sync`.

## Test plan

- **Clean lock.** Headers 16'hF628 every 27 words, random payload.
  - No start pulses for the first two headers.
  - Start on the third header's `data_out` cycle, and every 27 cycles after.
  - `sync_locked`=1.
- **False header in payload.** 16'hF628 at payload pos 10, no header 27 words later.
  - VERIFY→HUNT with no start pulse.
  - Lock is then acquired on the true header train.
- **Flywheel.** Locked; corrupt 3 consecutive headers.
  - Start pulses continue at the 27-cycle cadence.
  - `hdr_miss_cnt`=3, `sync_locked` stays 1.
  - A good header clears `miss_cnt`.
- **Loss of lock.** Corrupt 4 consecutive headers.
  - The 4th slot has no start pulse.
  - `lock_lost` pulses once, `sync_locked`→0, `hdr_miss_cnt`=4.
- **Saturation.** Preload via a long corrupted run with lock re-established between runs: `hdr_miss_cnt` holds at 16'hFFFF.
- **Reset mid-packet.** Assert `rst_n`=0 at pos 13 while locked.
  - All outputs are 0 immediately.
  - After release, the first start pulse is 55 cycles after the next header enters.
